// File: rtl/periodo_scheduler.sv
// Round-robin period meter: one shared counter walks over N_CH synchronized inputs,
// measuring rising-edge-to-rising-edge time per channel into a small result file.
module periodo_scheduler #(
    parameter int N_CH    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 255,
    parameter int SEL_W   = $clog2(N_CH)
) (
    input  logic             clock,
    input  logic             i_reset_n,
    input  logic [N_CH-1:0]  i_signals,
    input  logic             i_enable,
    input  logic [SEL_W-1:0] i_rd_sel,
    output logic [W-1:0]     o_rd_periodo,
    output logic             o_rd_valid,
    output logic             o_rd_err,
    output logic [SEL_W-1:0] o_ch_actual,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_STORE} state_t;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] TO_LAST = W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_CH-1:0]   r_sync1;
    logic [N_CH-1:0]   r_sync2;
    logic [N_CH-1:0]   r_sync3;
    logic [N_CH-1:0]   w_rise;
    logic              w_rise_sel;
    logic [W-1:0]      r_cnt;
    logic [W-1:0]      w_cnt_nxt;
    logic [W-1:0]      r_val;
    logic [W-1:0]      w_val_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [SEL_W-1:0]  r_ch;
    logic [SEL_W-1:0]  w_ch_nxt;
    logic [W-1:0]      r_periodo [N_CH];
    logic [N_CH-1:0]   r_valid;
    logic [N_CH-1:0]   r_errf;

    // Third flop gives a clean one-cycle rise pulse with equal latency for every edge.
    assign w_rise     = r_sync2 & ~r_sync3;
    assign w_rise_sel = w_rise[r_ch];

    // NOTE: sequential state uses non-blocking (<=) so all flops sample the same pre-edge values.
    always_ff @(posedge clock) begin
        if (!i_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= i_signals;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_val_nxt   = r_val;
        w_err_nxt   = r_err;
        w_ch_nxt    = r_ch;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (i_enable) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (!i_enable) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_rise_sel) begin
                    w_state_nxt = S_MEASURE;
                    w_cnt_nxt   = W'(1);
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = S_STORE;
                    w_val_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + W'(1);
                end
            end
            S_MEASURE: begin
                // A rise at full scale still counts as a good measurement.
                if (!i_enable) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_rise_sel) begin
                    w_state_nxt = S_STORE;
                    w_val_nxt   = r_cnt;
                    w_err_nxt   = 1'b0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = S_STORE;
                    w_val_nxt   = CNT_MAX;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + W'(1);
                end
            end
            S_STORE: begin
                w_cnt_nxt   = '0;
                w_ch_nxt    = r_ch + SEL_W'(1);
                w_state_nxt = i_enable ? S_ARM : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
            r_val <= '0;
            r_err <= 1'b0;
            r_ch  <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_val <= w_val_nxt;
            r_err <= w_err_nxt;
            r_ch  <= w_ch_nxt;
        end
    end

    // NOTE: the result file is a handful of flops that must read back as zero after reset, so it is reset explicitly.
    always_ff @(posedge clock) begin
        if (!i_reset_n) begin
            for (int k = 0; k < N_CH; k++) begin
                r_periodo[k] <= '0;
            end
            r_valid <= '0;
            r_errf  <= '0;
        end else if (r_state == S_STORE) begin
            r_periodo[r_ch] <= r_val;
            r_valid[r_ch]   <= ~r_err;
            r_errf[r_ch]    <= r_err;
        end
    end

    assign o_rd_periodo = r_periodo[i_rd_sel];
    assign o_rd_valid   = r_valid[i_rd_sel];
    assign o_rd_err     = r_errf[i_rd_sel];
    assign o_ch_actual  = r_ch;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_STORE);

endmodule

// File: tb/tb_periodo_scheduler.sv
// Scoreboard bench for periodo_scheduler: stimulus queues expected STORE results,
// a monitor pops and compares them on every o_done pulse.
module tb_periodo_scheduler;

    localparam int N_CH  = 4;
    localparam int W     = 8;
    localparam int SEL_W = 2;

    typedef struct {
        int ch;
        int val;
        int valid;
        int err;
    } exp_t;

    logic             clock;
    logic             i_reset_n;
    logic [N_CH-1:0]  sig;
    logic             i_enable;
    logic [SEL_W-1:0] stim_sel;
    logic [SEL_W-1:0] mon_sel;
    logic             mon_active;
    logic [SEL_W-1:0] rd_sel;
    logic [W-1:0]     o_rd_periodo;
    logic             o_rd_valid;
    logic             o_rd_err;
    logic [SEL_W-1:0] o_ch_actual;
    logic             o_busy;
    logic             o_done;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    int per   [N_CH] = '{default: 0};
    int start [N_CH] = '{default: 0};
    int cyc;

    assign rd_sel = mon_active ? mon_sel : stim_sel;

    periodo_scheduler #(.N_CH(N_CH), .W(W), .TIMEOUT(255), .SEL_W(SEL_W)) dut (
        .clock        (clock),
        .i_reset_n    (i_reset_n),
        .i_signals    (sig),
        .i_enable     (i_enable),
        .i_rd_sel     (rd_sel),
        .o_rd_periodo (o_rd_periodo),
        .o_rd_valid   (o_rd_valid),
        .o_rd_err     (o_rd_err),
        .o_ch_actual  (o_ch_actual),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Square-wave generator: phase 0 of each channel is a rising edge.
    initial begin
        sig = '0;
        cyc = 0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            for (int k = 0; k < N_CH; k++) begin
                if (per[k] == 0) sig[k] = 1'b0;
                else             sig[k] = (((cyc - start[k]) % per[k]) < (per[k] / 2));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic set_per(input int k, input int p);
        per[k]   = p;
        start[k] = cyc + 1;
    endtask

    task automatic push(input int ch, input int val, input int v, input int e);
        exp_t x;
        x.ch = ch; x.val = val; x.valid = v; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_ch(input int k, input int budget);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (o_ch_actual != SEL_W'(k) && n < budget);
        check("wait_ch", o_ch_actual, k);
    endtask

    task automatic read_chk(input int k, input int val, input int v, input int e);
        stim_sel = SEL_W'(k);
        #1;
        check("read_periodo", o_rd_periodo, val);
        check("read_valid", o_rd_valid, v);
        check("read_err", o_rd_err, e);
    endtask

    task automatic enable_on();
        check("idle_busy", o_busy, 0);
        i_enable = 1'b1;
        @(negedge clock);
        check("busy_after_enable", o_busy, 1);
    endtask

    task automatic abort_chk(input int ch);
        i_enable = 1'b0;
        @(negedge clock);
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        check("abort_ch", o_ch_actual, ch);
    endtask

    // Monitor: pops one expectation per STORE, checks channel and next-cycle readout.
    initial begin
        exp_t e;
        mon_active = 1'b0;
        mon_sel    = '0;
        forever begin
            @(negedge clock);
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", o_done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_ch", o_ch_actual, e.ch);
                    mon_sel    = SEL_W'(e.ch);
                    mon_active = 1'b1;
                    @(negedge clock);
                    check("next_ch", o_ch_actual, (e.ch + 1) % N_CH);
                    check("store_periodo", o_rd_periodo, e.val);
                    check("store_valid", o_rd_valid, e.valid);
                    check("store_err", o_rd_err, e.err);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        i_reset_n = 1'b0;
        i_enable  = 1'b0;
        stim_sel  = '0;
        repeat (4) @(negedge clock);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_ch", o_ch_actual, 0);
        for (int k = 0; k < N_CH; k++) read_chk(k, 0, 0, 0);
        i_reset_n = 1'b1;
        @(negedge clock);

        // Clean ch0, stuck ch1, ch2 saturating at 300, ch3 at 40.
        set_per(0, 20); set_per(1, 0); set_per(2, 0); set_per(3, 40);
        push(0, 20, 1, 0); push(1, 0, 0, 1); push(2, 255, 0, 1); push(3, 40, 1, 0);
        enable_on();
        wait_ch(1, 1000);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!o_done && n < 1000);
        check("timeout_latency", n, 255);
        wait_ch(2, 10);
        set_per(2, 300);
        wait_ch(3, 1000);
        set_per(2, 0);
        wait_ch(0, 1000);
        abort_chk(0);

        // ch2 at exactly 255: rise wins over saturation.
        set_per(0, 20); set_per(1, 0); set_per(2, 0); set_per(3, 40);
        push(0, 20, 1, 0); push(1, 0, 0, 1); push(2, 255, 1, 0); push(3, 40, 1, 0);
        enable_on();
        wait_ch(2, 2000);
        set_per(2, 255);
        wait_ch(3, 1000);
        set_per(2, 0);
        wait_ch(0, 1000);
        abort_chk(0);

        // Round-robin wrap with 10/20/30/40.
        set_per(0, 10); set_per(1, 20); set_per(2, 30); set_per(3, 40);
        push(0, 10, 1, 0); push(1, 20, 1, 0); push(2, 30, 1, 0); push(3, 40, 1, 0);
        enable_on();
        wait_ch(3, 1000);
        wait_ch(0, 1000);
        abort_chk(0);
        for (int k = 0; k < N_CH; k++) read_chk(k, (k + 1) * 10, 1, 0);

        // Edge isolation: fast edges on ch3 while ch0 is measured.
        set_per(0, 20); set_per(1, 0); set_per(2, 0); set_per(3, 6);
        push(0, 20, 1, 0);
        enable_on();
        wait_ch(1, 1000);
        abort_chk(1);

        // Abort mid-MEASURE on ch1: nothing stored, results retained.
        set_per(3, 0);
        set_per(1, 100);
        enable_on();
        repeat (50) @(negedge clock);
        abort_chk(1);
        read_chk(0, 20, 1, 0);
        read_chk(1, 20, 1, 0);
        read_chk(2, 30, 1, 0);
        read_chk(3, 40, 1, 0);

        // Reset mid-MEASURE clears everything.
        set_per(1, 100);
        enable_on();
        repeat (50) @(negedge clock);
        i_reset_n = 1'b0;
        i_enable  = 1'b0;
        @(negedge clock);
        check("midreset_busy", o_busy, 0);
        check("midreset_done", o_done, 0);
        check("midreset_ch", o_ch_actual, 0);
        for (int k = 0; k < N_CH; k++) read_chk(k, 0, 0, 0);
        i_reset_n = 1'b1;
        repeat (5) @(negedge clock);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/periodo_scheduler.md
# periodo_scheduler

Round-robin measurement controller that shares one period counter among `N_CH` asynchronous input signals. For each channel in turn it arms on a rising edge and counts clock cycles to the next rising edge. It stores the result in a per-channel result register with valid and error flags, then moves to the next channel. It sits between the board input pins and the display/readout logic, and replaces per-channel period meters with one sequenced datapath.

## Interface
- `N_CH`, 4, number of input channels; legal values are 2, 4 and 8.
- `W`, 8, width of the period counter and of each result register.
- `TIMEOUT`, 255, maximum cycles spent in ARM waiting for the first edge; must be in 1..2^W-1.
- `SEL_W`, log2(`N_CH`), width of the channel index.
- `clock`  input  1  system clock; every flop updates on its rising edge.
- `i_reset_n`  input  1  reset, synchronous, active-low.
- `i_signals`  input  `N_CH`  asynchronous signals to measure; bit k is channel k.
- `i_enable`  input  1  high: keep scheduling measurements; low: abort any measurement and return to IDLE.
- `i_rd_sel`  input  `SEL_W`  selects the channel presented on the readout outputs.
- `o_rd_periodo`  output  `W`  stored period of channel `i_rd_sel`, in clock cycles.
- `o_rd_valid`  output  1  channel `i_rd_sel` holds a good measurement.
- `o_rd_err`  output  1  last attempt on channel `i_rd_sel` timed out or saturated.
- `o_ch_actual`  output  `SEL_W`  channel currently being measured, or next to be measured.
- `o_busy`  output  1  high in ARM, MEASURE and STORE.
- `o_done`  output  1  one-cycle pulse in STORE.

## Operation
- **Input conditioning:** each `i_signals` bit passes through a 2-flop synchronizer and then a third flop. `rise[k]` = sync2 & ~sync3.
- **Edge selection:** only `rise[o_ch_actual]` is examined. Edges on other channels are ignored.
- **IDLE:** counter = 0. If `i_enable`=1, go to ARM.
- **ARM:** the counter acts as the timeout timer and increments every cycle.
  - On `rise`: go to MEASURE and load counter = 1.
  - If there is no rise and counter == `TIMEOUT`-1: go to STORE with err=1 and value=0.
- **MEASURE:** the counter increments every cycle in which there is no rise.
  - On `rise`: go to STORE with value=counter and err=0. This applies even when counter == 2^W-1.
  - If there is no rise and counter == 2^W-1: go to STORE with value=2^W-1 and err=1.
- **STORE (exactly 1 cycle):**
  - Write the result: reg[ch]=value, err[ch]=err, valid[ch]=~err.
  - Pulse `o_done`.
  - Update ch = (ch+1) mod `N_CH`; wrap from `N_CH`-1 to 0.
  - Next state is ARM if `i_enable`=1, otherwise IDLE.
- **Abort:** `i_enable`=0 in ARM or MEASURE takes priority over rise and timeout. Next state is IDLE, nothing is written, and ch is unchanged.
- **Readout:** combinational mux of reg/valid/err by `i_rd_sel`.
- **Result retention:** results persist until overwritten by the next STORE for that channel.
- **Counter width:** the counter is `W` bits and never wraps in MEASURE.

## Timing
- **Reset:** while `i_reset_n`=0 at a clock edge:
  - state=IDLE, ch=0, counter=0;
  - all reg/valid/err=0, synchronizer flops=0;
  - `o_busy`=0, `o_done`=0, `o_ch_actual`=0.
- **Mid-operation reset:** reset during ARM or MEASURE discards the measurement. No STORE occurs.
- **Period definition:** if `rise` is seen in ARM at cycle t0 and in MEASURE at t1, the stored value is t1-t0. A square wave of period P clocks therefore yields P.
- **Pin-to-rise latency:** 3 cycles, identical for both edges, so it does not affect the result.
- **STORE to ARM:** ARM of channel ch+1 starts the cycle after STORE.
- **Readout update:** the readout reflects a STORE in the cycle following it.
- **ARM timeout:** STORE occurs exactly `TIMEOUT` cycles after entering ARM.
- **Enable from IDLE:** `o_busy` rises the cycle after `i_enable` is sampled high in IDLE.

## Test plan
- **Clean measurement:** reset, `i_enable`=1, ch0 square wave of period 20 clocks → first STORE has ch0 reg=20, valid=1, err=0; `o_ch_actual` becomes 1.
- **Stuck channel:** ch1 held low → STORE 255 cycles after ARM entry; reg1=0, valid1=0, err1=1; scheduler moves on to ch2.
- **Saturation boundaries:**
  - ch2 period 300 clocks → reg2=255, err2=1.
  - ch2 period 255 clocks → reg2=255, valid2=1 (rise wins at saturation).
- **Round-robin wrap:** all channels with periods 10/20/30/40 → four `o_done` pulses; `o_ch_actual` cycles 0,1,2,3,0; reading sel 0..3 returns 10,20,30,40.
- **Abort and reset:**
  - Drop `i_enable` mid-MEASURE → IDLE next cycle, no `o_done`, previous results intact, ch unchanged.
  - Assert `i_reset_n`=0 mid-MEASURE → all outputs 0.
- **Edge isolation:** rising edges on ch3 while ch0 is being measured → ch0 result unaffected, `o_done` only at ch0's second edge.
